// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_core transmitter among NUM_REQ requesters.
// Accepts words over valid/ready, drives start_tx/tx_data, waits for tx_done or times out.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         req_done_o,
    input  logic                       cts_n_i,
    input  logic                       tx_done_i,
    output logic [DATA_W-1:0]          tx_data_o,
    output logic                       start_tx_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       timeout_o
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] ToLast = CntW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]    grant_q, grant_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic              win_found;
    logic [IdW-1:0]    win_id;
    int unsigned       scan_idx;

    // Scan starts one past the last served requester so every index gets its turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!win_found && req_valid_i[IdW'(scan_idx)]) begin
                win_found = 1'b1;
                win_id    = IdW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        tx_data_d   = tx_data_q;
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        req_ready_o = '0;
        req_done_o  = '0;
        start_tx_o  = 1'b0;

        case (state_q)
            StIdle: begin
                if (en_i && !cts_n_i && win_found) begin
                    req_ready_o = OneHot0 << win_id;
                    tx_data_d   = req_data_i[32'(win_id) * DATA_W +: DATA_W];
                    grant_d     = win_id;
                    state_d     = StStart;
                end
            end
            StStart: begin
                start_tx_o = 1'b1;
                state_d    = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A done pulse on the timeout cycle still counts as a completion.
                if (tx_done_i) begin
                    rr_ptr_d = grant_q;
                    state_d  = StDone;
                end else if (TIMEOUT_CYC != 0 && cnt_q == ToLast) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = grant_q;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end
            end
            StDone: begin
                req_done_o = OneHot0 << grant_q;
                cnt_d      = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_ptr_q  <= IdW'(NUM_REQ - 1);
            grant_q   <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign grant_id_o = grant_q;
    assign tx_data_o  = tx_data_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized transfers
// checked against a transfer-level round-robin model.
module tb_uart_tx_sched;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int TO = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              cts_n;
    logic              tx_done;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_done;
    logic [DW-1:0]     tx_data;
    logic              start_tx;
    logic              busy;
    logic [1:0]        grant_id;
    logic              timeout;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_srv;
    logic [DW-1:0] last_word;
    bit          pend_to;
    int          acc_cyc[$];
    int          gnt_hist[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sched #(
        .NUM_REQ    (NR),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_ready_o(req_ready),
        .req_done_o (req_done),
        .cts_n_i    (cts_n),
        .tx_done_i  (tx_done),
        .tx_data_o  (tx_data),
        .start_tx_o (start_tx),
        .busy_o     (busy),
        .grant_id_o (grant_id),
        .timeout_o  (timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Next owner: first valid index after the last one served, wrapping around.
    function automatic int model_winner(input logic [NR-1:0] m);
        for (int i = 1; i <= NR; i++) begin
            if (m[(last_srv + i) % NR]) return (last_srv + i) % NR;
        end
        return 0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; en = 1'b1; cts_n = 1'b0; tx_done = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_start", start_tx, 0);
        check("rst_ready", req_ready, 0);
        check("rst_done", req_done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant", grant_id, 0);
        next_cycle();
        rst      = 1'b0;
        last_srv = NR - 1;
        last_word = '0;
        pend_to  = 1'b0;
    endtask

    // One transfer from IDLE. dly: WAIT cycle carrying tx_done (>TO means never).
    // stall cycles are blocked by cts_n (kind 0) or en (kind 1); rst_at>0 resets mid-WAIT.
    task automatic run_xfer(input logic [NR-1:0] mask, input int dly, input int stall,
                            input int kind, input bit noise, input int rst_at,
                            input bit fix, input logic [DW-1:0] fw);
        int w;
        logic [DW-1:0] word;
        for (int k = 0; k < NR; k++) req_data[k*DW +: DW] = fix ? fw : DW'($urandom);
        req_valid = mask;
        if (stall > 0) begin
            if (kind == 0) cts_n = 1'b1;
            else en = 1'b0;
        end
        for (int s = 0; s < stall; s++) begin
            tx_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check("stall_ready", req_ready, 0);
            check("stall_busy", busy, 0);
            check("stall_timeout", timeout, 64'(pend_to));
            check("hold_data", tx_data, last_word);
            pend_to = 1'b0;
            next_cycle();
        end
        cts_n = 1'b0; en = 1'b1; tx_done = 1'b0;
        w    = model_winner(mask);
        word = req_data[w*DW +: DW];
        @(negedge clk);
        check("accept_ready", req_ready, onehot(w));
        check("accept_timeout", timeout, 64'(pend_to));
        check("accept_done", req_done, 0);
        check("accept_busy", busy, 0);
        pend_to = 1'b0;
        acc_cyc.push_back(cyc);
        next_cycle();
        req_valid[w] = 1'b0;
        tx_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        check("start_pulse", start_tx, 1);
        check("start_data", tx_data, word);
        check("start_grant", grant_id, w);
        check("start_busy", busy, 1);
        check("start_ready", req_ready, 0);
        check("start_timeout", timeout, 0);
        gnt_hist.push_back(int'(grant_id));
        last_word = word;
        next_cycle();
        for (int c = 1; c <= TO; c++) begin
            tx_done = (c == dly);
            if (c == rst_at) begin
                rst = 1'b1;
                req_valid = '0;
            end
            @(negedge clk);
            check("wait_start", start_tx, 0);
            check("wait_done", req_done, 0);
            check("wait_timeout", timeout, 0);
            check("wait_busy", busy, 1);
            next_cycle();
            tx_done = 1'b0;
            if (c == rst_at) begin
                rst = 1'b0;
                @(negedge clk);
                check("midrst_busy", busy, 0);
                check("midrst_start", start_tx, 0);
                check("midrst_done", req_done, 0);
                check("midrst_timeout", timeout, 0);
                check("midrst_grant", grant_id, 0);
                last_srv  = NR - 1;
                last_word = '0;
                next_cycle();
                return;
            end
            if (c == dly) break;
        end
        last_srv = w;
        if (dly <= TO) begin
            tx_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            check("done_pulse", req_done, onehot(w));
            check("done_timeout", timeout, 0);
            check("done_busy", busy, 1);
            check("done_ready", req_ready, 0);
            next_cycle();
            tx_done = 1'b0;
        end else begin
            pend_to = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; cts_n = 1'b0; tx_done = 1'b0; req_valid = '0; req_data = '0;
        do_reset();

        // Single requester, word 0xA5, done 10 cycles after start.
        run_xfer(4'b0001, 10, 0, 0, 1'b0, 0, 1'b1, 32'hA5);

        // All valid: order 0,1,2,3,0 with accepts 6 cycles apart.
        do_reset();
        acc_cyc.delete();
        gnt_hist.delete();
        repeat (5) run_xfer(4'b1111, 3, 0, 0, 1'b0, 0, 1'b0, '0);
        for (int i = 0; i < 5; i++) check("fair_order", gnt_hist[i], i % NR);
        for (int i = 1; i < 5; i++) check("fair_spacing", acc_cyc[i] - acc_cyc[i-1], 6);

        // cts_n held high for 20 cycles, then req 2 granted immediately.
        run_xfer(4'b0100, 5, 20, 0, 1'b0, 0, 1'b0, '0);

        // Timeout on req 1, then the grant moves on to req 2.
        run_xfer(4'b0010, 1000, 0, 0, 1'b0, 0, 1'b0, '0);
        run_xfer(4'b1111, 2, 0, 0, 1'b0, 0, 1'b0, '0);

        // tx_done lands on the timeout cycle.
        run_xfer(4'b1001, TO, 0, 0, 1'b0, 0, 1'b0, '0);

        // Reset in WAIT, next grant restarts from 0.
        run_xfer(4'b0100, 1000, 0, 0, 1'b0, 5, 1'b0, '0);
        run_xfer(4'b1111, 1, 0, 0, 1'b0, 0, 1'b0, '0);

        for (int n = 0; n < 40; n++) begin
            run_xfer(NR'($urandom_range(1, (1 << NR) - 1)), int'($urandom_range(1, TO + 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1'b1, 0,
                     1'b0, '0);
        end

        req_valid = '0;
        @(negedge clk);
        check("final_timeout", timeout, 64'(pend_to));
        check("final_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
